// File: rtl/pe_result_collector_pkg.sv
// Shared accelerator definitions: default widths, shift-field width and the
// pure requantize function used by the collector and by golden models.
package pe_result_collector_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int OUT_WIDTH_DEF  = 8;
  localparam int SHIFT_W        = 4;

  // Working width for requantization. It covers any PE word up to 32 bits
  // plus the rounding carry, so results match DATA_WIDTH+1 bit arithmetic.
  localparam int REQ_W = 40;

  // Rounding arithmetic shift (round-half-up), optional ReLU, then signed
  // saturation to out_w bits. The result is returned sign-extended to REQ_W.
  function automatic logic signed [REQ_W-1:0] requantize(
    input logic signed [REQ_W-1:0] x,
    input logic [SHIFT_W-1:0]      shift,
    input logic                    relu,
    input int                      out_w
  );
    logic signed [REQ_W-1:0] rnd;
    logic signed [REQ_W-1:0] r;
    logic signed [REQ_W-1:0] max_v;
    logic signed [REQ_W-1:0] min_v;
    // 2^(shift-1) for shift>0, zero for shift==0
    rnd = REQ_W'(1) << shift;
    rnd = rnd >>> 1;
    r   = (x + rnd) >>> shift;
    if (relu && (r < 0)) begin
      r = '0;
    end
    max_v = (REQ_W'(1) << (out_w - 1)) - REQ_W'(1);
    min_v = -max_v - REQ_W'(1);
    if (r > max_v) begin
      r = max_v;
    end else if (r < min_v) begin
      r = min_v;
    end
    return r;
  endfunction

endpackage

// File: rtl/pe_result_collector_fifo.sv
// Small synchronous result FIFO. Head data is read straight from the storage
// registers, so the output never depends combinationally on pop. A push into
// a full FIFO is accepted only when a pop frees a slot in the same cycle; a
// push and pop on an empty FIFO does not bypass.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_do_pop;
  logic             w_do_push;
  logic [DEPTH-1:0] w_we;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_pop  = pop && !w_empty;
  assign w_do_push = push && (!w_full || w_do_pop);

  // One write enable per storage slot, decoded from the write pointer
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign w_we[gi] = w_do_push && !clr && (r_wr_ptr == AW'(gi));
    end
  endgenerate

  // Storage slots; cleared on reset so the head reads zero out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_we[i]) begin
          r_mem[i] <= push_data;
        end
      end
    end
  end

  // Pointers and occupancy; clear overrides any same-cycle push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign full    = w_full;
  assign empty   = w_empty;
  assign count   = r_count;

endmodule

// File: rtl/pe_result_collector.sv
// Tracks PE timing by counting enable pulses, captures the PE output once a
// dot product of cfg_len+1 pulses has drained, requantizes it and queues the
// result on a valid/ready stream. Drops on a full FIFO raise a sticky flag.
module pe_result_collector
  import pe_result_collector_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int LEN_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         pe_en,
  input  logic signed [DATA_WIDTH-1:0] pe_output_data,
  input  logic [LEN_WIDTH-1:0]         cfg_len,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  input  logic                         cfg_relu,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic                         busy,
  output logic [CNT_W-1:0]             fifo_count
);

  logic [LEN_WIDTH:0]      r_en_cnt;
  logic                    r_cap_pend;
  logic                    r_overflow;

  logic                    w_last_term;
  logic signed [REQ_W-1:0] w_q_full;
  logic [OUT_WIDTH-1:0]    w_q;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [OUT_WIDTH-1:0]    w_head;
  logic [CNT_W-1:0]        w_count;

  // The (K+1)th pulse is the one that exposes the finished sum on the PE
  assign w_last_term = (r_en_cnt == {1'b0, cfg_len});

  // Requantize whatever the PE presents; only used in the capture cycle
  assign w_q_full = requantize(REQ_W'(pe_output_data), cfg_shift, cfg_relu, OUT_WIDTH);
  assign w_q      = OUT_WIDTH'(w_q_full);

  assign w_push = r_cap_pend;
  assign w_pop  = !w_empty && out_ready;

  // Enable counter and pending-capture flag; a pulse in the capture cycle
  // counts toward the next result so back-to-back results need no gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_cnt   <= '0;
      r_cap_pend <= 1'b0;
    end else if (clr) begin
      r_en_cnt   <= '0;
      r_cap_pend <= 1'b0;
    end else begin
      if (r_cap_pend) begin
        r_cap_pend <= 1'b0;
      end
      if (pe_en) begin
        if (w_last_term) begin
          r_en_cnt   <= '0;
          r_cap_pend <= 1'b1;
        end else begin
          r_en_cnt <= r_en_cnt + (LEN_WIDTH+1)'(1);
        end
      end
    end
  end

  // Sticky drop flag: capture while full with no pop freeing a slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  result_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (w_push),
    .push_data (w_q),
    .pop       (w_pop),
    .rd_data   (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  assign out_valid  = !w_empty;
  assign out_data   = w_head;
  assign overflow   = r_overflow;
  assign busy       = (r_en_cnt != '0) || r_cap_pend;
  assign fifo_count = w_count;

endmodule

// File: tb/tb_pe_result_collector.sv
// Directed bench for pe_result_collector: drain latency, requantization
// corners, back-to-back results, overflow, backpressure, reset and clear.
module tb_pe_result_collector;

  logic               clk;
  logic               rst_n;
  logic               clr;
  logic               pe_en;
  logic signed [15:0] pe_output_data;
  logic [7:0]         cfg_len;
  logic [3:0]         cfg_shift;
  logic               cfg_relu;
  logic               out_valid;
  logic signed [7:0]  out_data;
  logic               out_ready;
  logic               overflow;
  logic               busy;
  logic [2:0]         fifo_count;

  int n_vec = 0;
  int n_err = 0;

  pe_result_collector #(
    .DATA_WIDTH (16),
    .OUT_WIDTH  (8),
    .LEN_WIDTH  (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .pe_en          (pe_en),
    .pe_output_data (pe_output_data),
    .cfg_len        (cfg_len),
    .cfg_shift      (cfg_shift),
    .cfg_relu       (cfg_relu),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready),
    .overflow       (overflow),
    .busy           (busy),
    .fifo_count     (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // K=0 single result through the requantizer, then popped
  task automatic one_result(input string tag, input int x, input int s,
                            input logic relu, input int exp);
    cfg_len        = 8'd0;
    cfg_shift      = s[3:0];
    cfg_relu       = relu;
    pe_output_data = x[15:0];
    pe_en = 1'b1;
    tick();
    pe_en = 1'b0;
    tick();
    chk(tag, out_data, exp);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    cfg_relu  = 1'b0;
  endtask

  // K=0, no pops, 5 pulses: results 2,3,4,5 stored, 6 dropped
  task automatic fill_overflow();
    out_ready = 1'b0;
    cfg_len   = 8'd0;
    cfg_shift = 4'd0;
    for (int c = 0; c < 6; c++) begin
      pe_en          = (c < 5);
      pe_output_data = 16'(c + 1);
      tick();
    end
    pe_en = 1'b0;
  endtask

  initial begin
    int exp_tail [3];
    clk = 1'b0; rst_n = 1'b0; clr = 1'b0; pe_en = 1'b0;
    pe_output_data = '0; cfg_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
    out_ready = 1'b0;

    // reset state
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    rst_n = 1'b1;
    tick();

    // basic drain: K=3, shift 2, 300 -> 75
    cfg_len = 8'd3; cfg_shift = 4'd2; pe_output_data = 16'sd300;
    pe_en = 1'b1;
    repeat (3) tick();
    chk("basic_busy", busy, 1);
    tick();
    pe_en = 1'b0;
    chk("basic_lat1_valid", out_valid, 0);
    tick();
    chk("basic_lat2_valid", out_valid, 1);
    chk("basic_data", out_data, 75);
    chk("basic_count", fifo_count, 1);
    chk("basic_idle", busy, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("basic_popped", out_valid, 0);

    // rounding, sign, relu, saturation
    one_result("rnd_7_s1", 7, 1, 1'b0, 4);
    one_result("rnd_m6_s2", -6, 2, 1'b0, -1);
    one_result("relu_m5", -5, 0, 1'b1, 0);
    one_result("sat_pos", 300, 0, 1'b0, 127);
    one_result("sat_neg", -300, 0, 1'b0, -128);

    // back-to-back K=0: one result per cycle in order
    cfg_len = 8'd0; cfg_shift = 4'd0; out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      pe_en          = (c < 6);
      pe_output_data = 16'(10 * c);
      tick();
      if (c >= 1 && c <= 6) begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_data", out_data, 10 * c);
      end
    end
    pe_en = 1'b0;
    chk("b2b_drained", fifo_count, 0);
    out_ready = 1'b0;

    // overflow then push accepted while full with a pop
    fill_overflow();
    chk("ovf_count", fifo_count, 4);
    chk("ovf_flag", overflow, 1);
    chk("ovf_head", out_data, 2);
    pe_en = 1'b1;
    tick();
    pe_en = 1'b0;
    pe_output_data = 16'sd77;
    out_ready = 1'b1;
    tick();
    chk("fullpp_count", fifo_count, 4);
    chk("fullpp_head", out_data, 3);
    exp_tail[0] = 4; exp_tail[1] = 5; exp_tail[2] = 77;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fullpp_drain", out_data, exp_tail[i]);
    end
    tick();
    chk("fullpp_empty", fifo_count, 0);
    out_ready = 1'b0;

    // clear while full with overflow; same-cycle pe_en ignored
    fill_overflow();
    chk("clr_pre_ovf", overflow, 1);
    clr = 1'b1; pe_en = 1'b1;
    tick();
    clr = 1'b0; pe_en = 1'b0;
    chk("clr_count", fifo_count, 0);
    chk("clr_overflow", overflow, 0);
    chk("clr_valid", out_valid, 0);
    chk("clr_busy", busy, 0);

    // backpressure: 11,22,33 queued, stall in the middle
    cfg_len = 8'd0; out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pe_en          = (c < 3);
      pe_output_data = 16'(11 * c);
      tick();
    end
    pe_en = 1'b0;
    chk("bp_count", fifo_count, 3);
    chk("bp_head", out_data, 11);
    out_ready = 1'b1;
    tick();
    chk("bp_pop1", out_data, 22);
    out_ready = 1'b0;
    tick();
    chk("bp_hold1", out_data, 22);
    tick();
    chk("bp_hold2", out_data, 22);
    chk("bp_hold_count", fifo_count, 2);
    out_ready = 1'b1;
    tick();
    chk("bp_pop2", out_data, 33);
    tick();
    chk("bp_empty", fifo_count, 0);
    out_ready = 1'b0;

    // async reset after 2 of 4 pulses, then a fresh full drain
    cfg_len = 8'd3; cfg_shift = 4'd0; pe_output_data = 16'sd40;
    pe_en = 1'b1;
    tick(); tick();
    pe_en = 1'b0;
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", fifo_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    pe_en = 1'b1;
    repeat (4) tick();
    pe_en = 1'b0;
    tick();
    chk("post_rst_count", fifo_count, 1);
    chk("post_rst_data", out_data, 40);
    repeat (3) tick();
    chk("post_rst_single", fifo_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_result_collector.md
# pe_result_collector

Downstream stage of the processing element (PE): watches the PE's enable stream, captures the PE's registered output once a dot product of configured length has drained, and requantizes it (rounding shift, optional ReLU, signed saturation). Results are buffered in a small FIFO and presented on a valid/ready stream to the next layer or the writeback path. Holds no multiply-accumulate state; PE timing is tracked purely by counting enable pulses.

## Interface
- DATA_WIDTH, 16: width of the PE output word (signed).
- OUT_WIDTH, 8: width of the requantized result (signed).
- LEN_WIDTH, 8: width of `cfg_len`.
- FIFO_DEPTH, 4: result FIFO entries; power of two, at least 2.
- clk  in  1: single clock, rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- clr  in  1: synchronous clear of the counter, the pending capture, the FIFO and `overflow`.
- pe_en  in  1: same signal that drives the PE's `en`.
- pe_output_data  in  DATA_WIDTH: the PE's `output_data`, signed.
- cfg_len  in  LEN_WIDTH: K, the number of MAC terms per result. Must be stable while `busy`=1.
- cfg_shift  in  4: arithmetic right-shift amount, 0..15.
- cfg_relu  in  1: 1 = clamp negative values to 0 before saturation.
- out_valid  out  1: FIFO head is valid.
- out_data  out  OUT_WIDTH: FIFO head, signed.
- out_ready  in  1: consumer accepts the head.
- overflow  out  1: sticky; a result was dropped because the FIFO was full.
- busy  out  1: high when the enable count is non-zero or a capture is pending.
- fifo_count  out  $clog2(FIFO_DEPTH)+1: current number of FIFO entries.

## Operation
- PE latency: the PE's output register updates on the same edge that samples `en`, using the pre-update accumulator. After K MAC pulses, one more pulse is needed to expose the sum, so a result needs K+1 `pe_en` pulses.
- Counter `en_cnt`, LEN_WIDTH+1 bits, counts `pe_en` high cycles.
  - When `pe_en`=1 and `en_cnt`==cfg_len: `en_cnt`←0 and `cap_pend`←1.
  - Otherwise, on `pe_en`=1: `en_cnt`++.
  - K=0 is legal; every pulse then produces a result.
- Capture: in the cycle with `cap_pend`=1, requantize `pe_output_data`, push the result, and clear `cap_pend`. A `pe_en` in this same cycle counts normally toward the next result, so back-to-back results need no gap.
- Requantize, all arithmetic in DATA_WIDTH+1 signed bits:
  - s=0: r=x.
  - s>0: r=(x + 2^(s-1)) >>> s. This is round-half-up, i.e. rounding toward +inf on ties.
  - If `cfg_relu` and r<0: r=0.
  - Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - `cfg_shift` and `cfg_relu` are sampled in the capture cycle.
- FIFO:
  - Push is accepted if it is not full, or if it is full and a pop happens in the same cycle.
  - A push to a full FIFO with no pop drops the result and sets `overflow`.
  - Pop occurs when `out_valid` && `out_ready`.
  - Push and pop together on an empty FIFO: no bypass. The result appears on the next cycle.
- `clr` has priority over every same-cycle event: `en_cnt`=0, `cap_pend`=0, FIFO empty, `overflow`=0. Any `pe_en` in that cycle is ignored.

## Timing
- Reset values, asserted asynchronously: out_valid=0, out_data=0, overflow=0, busy=0, fifo_count=0, en_cnt=0, cap_pend=0.
- Latency: from the edge sampling the (K+1)th `pe_en` to `out_valid`=1 is 2 cycles when the FIFO was empty (capture edge, then the FIFO write).
- `out_data` and `out_valid` are registered, driven directly from FIFO storage and count; no combinational path from `out_ready`.
- `out_data` holds stable while `out_valid`=1 and `out_ready`=0.
- Reset mid-operation: partial count and pending capture are lost. The PE must be reset in the same window; the system controller guarantees this.
- Throughput: one result per K+1 cycles at most, and one result per cycle at K=0.

## Structure
- Shared accelerator package holds:
  - default DATA_WIDTH/OUT_WIDTH;
  - the requantize function (shift, round, ReLU, saturate) as a pure function, reused by the golden model;
  - `SHIFT_W`=4.
- One sub-module, `result_fifo`: synchronous FIFO with async active-low reset, full/empty/count outputs, and simultaneous push/pop allowed when full.
- Top level holds `en_cnt`, `cap_pend`, requantization, and `overflow`.

## Test plan
- Basic drain: K=3, shift=2, relu=0, PE output 300 at capture → out_data=75, out_valid 2 cycles after the 4th pulse.
- Rounding and sign:
  - 7, shift 1 → 4.
  - −6, shift 2 → −1.
  - −5, shift 0, relu=1 → 0.
  - 300, shift 0 → 127.
  - −300, shift 0 → −128.
- Back-to-back with K=0: `pe_en` held 6 cycles, out_ready=1 → 6 results, one per cycle, in order.
- Overflow: K=0, out_ready=0, 5 pulses → fifo_count=4, overflow=1, FIFO holds the first 4 results. Then out_ready=1 with a push on the same cycle as full → push accepted.
- Backpressure: out_ready toggled 1-0-1 with 3 queued results → `out_data` held while stalled, no loss or duplication.
- Reset/clear:
  - rst_n low after 2 of 4 pulses → all outputs 0; the next 4 pulses produce exactly one result.
  - clr while full with overflow=1 → fifo_count=0, overflow=0.
